adder_sequencer: RTL and testbench

- Multi-precision add/subtract controller for the CPU's 8-bit ripple adder (ports A, B, Carry_in, Sum, Carry_out).
- Accepts NUM_BYTES-wide operands and feeds them through the single 8-bit adder one byte per cycle, LSB first, chaining carry between bytes.
- Sits between the execute stage and the shared Adder instance.
- Produces the wide result plus carry, signed-overflow and zero flags, with a start/busy/done handshake.

---
 rtl/adder_sequencer.sv | 143 ++++++++++++++
 tb/tb_adder_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sequencer.sv
// adder_sequencer: drives a shared 8-bit ripple adder one byte per cycle,
// LSB first, to build a NUM_BYTES-wide add/subtract with carry, signed
// overflow and zero flags behind a start/busy/done handshake.
module adder_sequencer #(
    parameter int NUM_BYTES = 4,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic                   cin,
    input  logic [8*NUM_BYTES-1:0] a_in,
    input  logic [8*NUM_BYTES-1:0] b_in,
    output logic                   busy,
    output logic                   done,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   carry_out,
    output logic                   overflow,
    output logic                   zero,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    output logic                   add_cin,
    input  logic [7:0]             add_sum,
    input  logic                   add_cout
);

    localparam int               W        = 8 * NUM_BYTES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_sub;
    logic [W-1:0]     r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic [7:0]       w_a_byte;
    logic [7:0]       w_b_byte;
    logic             w_lower_zero;
    logic             w_ovf;

    assign w_run = (r_state == S_RUN);

    // Select the operand bytes addressed by the current byte index.
    always_comb begin
        w_a_byte = 8'h00;
        w_b_byte = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_byte = r_a[8*i +: 8];
                w_b_byte = r_b[8*i +: 8];
            end
        end
    end

    // Adder inputs are only live while running; B is pre-inverted for subtract.
    assign add_a   = w_run ? w_a_byte : 8'h00;
    assign add_b   = w_run ? (r_sub ? ~w_b_byte : w_b_byte) : 8'h00;
    assign add_cin = w_run & r_carry;

    // Flags are evaluated on the top byte; lower bytes are already in r_result.
    assign w_lower_zero = (r_result[W-9:0] == '0);
    assign w_ovf        = (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);

    // Sequencer FSM: latch on start, walk bytes LSB first, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sub    <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a_in;
                        r_b     <= b_in;
                        r_sub   <= op_sub;
                        r_carry <= op_sub | cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < NUM_BYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_result[8*i +: 8] <= add_sum;
                        end
                    end
                    r_carry <= add_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= add_cout;
                        r_ovf   <= w_ovf;
                        r_zero  <= w_lower_zero && (add_sum == 8'h00);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed flag/boundary cases, mid-run
// interference, asynchronous reset and a back-to-back random run against a
// wide-arithmetic reference model. The shared 8-bit Adder is modelled here.
module tb_adder_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    adder_sequencer #(.NUM_BYTES(NB), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .cin(cin),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // The shared 8-bit ripple adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Wide reference: plain W-bit arithmetic and two's-complement sign rules.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic c_in,
                                  output logic [W-1:0] r, output logic co,
                                  output logic ov, output logic zo);
        logic [W:0] full;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            co   = ~full[W];
            r    = full[W-1:0];
            ov   = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + (W+1)'(c_in);
            co   = full[W];
            r    = full[W-1:0];
            ov   = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end
        zo = (r == '0);
    endfunction

    // Issue one request from IDLE and observe it; leaves the bench in IDLE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic c_in,
                         output int dcyc, output int ndone, output logic busy_ok,
                         output logic [W-1:0] r, output logic co,
                         output logic ov, output logic zo);
        a_in = a; b_in = b; op_sub = sub; cin = c_in; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcyc = 0; ndone = 0; busy_ok = 1'b1;
        r = 'x; co = 1'bx; ov = 1'bx; zo = 1'bx;
        for (int n = 1; n <= NB + 4; n++) begin
            if (done === 1'b1) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = n; r = result; co = carry_out; ov = overflow; zo = zero;
                end
            end
            if (busy !== (n <= NB + 1)) busy_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({busy, done, result, carry_out, overflow, zero, add_a, add_b, add_cin} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h flags=%b%b%b add=%h/%h/%b required all zero",
                     busy, done, result, carry_out, overflow, zero, add_a, add_b, add_cin);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int dc, nd; logic bok; logic [W-1:0] r; logic co, ov, zo;
        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if (dc != NB + 1 || nd != 1) begin
            n_fail++; $display("FAIL add_done_timing: got cycle %0d count %0d required cycle %0d count 1", dc, nd, NB + 1);
        end
        n_tests++;
        if (!bok) begin n_fail++; $display("FAIL add_busy_window: got busy outside cycles 1-%0d required inside only", NB + 1); end
        n_tests++;
        if ({r, co, ov, zo} !== {32'h0000_0100, 3'b000}) begin
            n_fail++; $display("FAIL add_carry_chain: got %h c%b v%b z%b required 00000100 c0 v0 z0", r, co, ov, zo);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (result !== 32'h0000_0100 || busy !== 1'b0) begin
            n_fail++; $display("FAIL result_hold: got %h busy %b required 00000100 busy 0", result, busy);
        end
    endtask

    task automatic test_add_flags();
        int dc, nd; logic bok; logic [W-1:0] r; logic co, ov, zo;
        do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if ({r, co, ov, zo} !== {32'h0, 3'b101}) begin
            n_fail++; $display("FAIL add_wrap_zero: got %h c%b v%b z%b required 00000000 c1 v0 z1", r, co, ov, zo);
        end
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if ({r, co, ov, zo} !== {32'h8000_0000, 3'b010}) begin
            n_fail++; $display("FAIL add_overflow: got %h c%b v%b z%b required 80000000 c0 v1 z0", r, co, ov, zo);
        end
    endtask

    task automatic test_sub();
        int dc, nd; logic bok; logic [W-1:0] r; logic co, ov, zo;
        do_op(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if ({r, co, ov, zo} !== {32'hFFFF_FFFF, 3'b000}) begin
            n_fail++; $display("FAIL sub_borrow: got %h c%b v%b z%b required ffffffff c0 v0 z0", r, co, ov, zo);
        end
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if ({r, co, ov, zo} !== {32'h7FFF_FFFF, 3'b110}) begin
            n_fail++; $display("FAIL sub_overflow: got %h c%b v%b z%b required 7fffffff c1 v1 z0", r, co, ov, zo);
        end
        // Adder port drive on the first RUN cycle of a subtract (cin ignored).
        a_in = 32'hA5C3_1E69; b_in = 32'h0F0F_3C5A; op_sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if ({add_a, add_b, add_cin} !== {8'h69, 8'hA5, 1'b1}) begin
            n_fail++; $display("FAIL sub_adder_ports: got a=%h b=%h cin=%b required a=69 b=a5 cin=1", add_a, add_b, add_cin);
        end
        repeat (NB + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_start_ignored();
        int nd = 0; int nbusy = 0; logic [W-1:0] r = 'x;
        a_in = 32'h1122_3344; b_in = 32'h0101_0101; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'h1234_5678; op_sub = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a_in = 32'h5555_5555;
        for (int n = 3; n <= NB + 10; n++) begin
            if (busy === 1'b1) nbusy++;
            if (done === 1'b1) begin nd++; r = result; end
            @(posedge clk); #1;
        end
        n_tests++;
        if (r !== 32'h1223_3445 || nd != 1) begin
            n_fail++; $display("FAIL start_while_busy: got %h done_count %0d required 12233445 done_count 1", r, nd);
        end
        n_tests++;
        if (nbusy != NB - 1) begin
            n_fail++; $display("FAIL no_second_op: got %0d busy cycles required %0d", nbusy, NB - 1);
        end
    endtask

    task automatic test_async_reset();
        int dc, nd; logic bok; logic [W-1:0] r; logic co, ov, zo;
        a_in = 32'hFFFF_FFFF; b_in = 32'h8000_0001; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, result, carry_out, overflow, zero, add_a, add_b, add_cin} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got busy=%b done=%b result=%h flags=%b%b%b add=%h/%h/%b required all zero",
                     busy, done, result, carry_out, overflow, zero, add_a, add_b, add_cin);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, dc, nd, bok, r, co, ov, zo);
        n_tests++;
        if (r !== 32'h2345_6789 || dc != NB + 1 || !bok) begin
            n_fail++; $display("FAIL after_reset_add: got %h at cycle %0d busy_ok %b required 23456789 at cycle %0d", r, dc, bok, NB + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [0:200];
        logic [W-1:0] vb [0:200];
        logic         vs [0:200];
        logic         vc [0:200];
        logic [W-1:0] er; logic eco, eov, ezo;
        int n, last_done, bad_data, bad_time;
        bad_data = 0; bad_time = 0; last_done = -1;
        for (int i = 0; i <= 200; i++) begin
            for (int k = 0; k < NB; k++) begin
                va[i][8*k +: 8] = 8'($urandom_range(0, 255));
                vb[i][8*k +: 8] = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 7) == 0) vb[i] = va[i];
            if ($urandom_range(0, 7) == 0) vb[i] = -va[i];
            vs[i] = 1'($urandom_range(0, 1));
            vc[i] = 1'($urandom_range(0, 1));
        end
        a_in = va[0]; b_in = vb[0]; op_sub = vs[0]; cin = vc[0]; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) begin
            a_in = va[i+1]; b_in = vb[i+1]; op_sub = vs[i+1]; cin = vc[i+1];
            n = 1;
            while (done !== 1'b1 && n < NB + 6) begin
                @(posedge clk); #1;
                n++;
            end
            model(va[i], vb[i], vs[i], vc[i], er, eco, eov, ezo);
            n_tests++;
            if (done !== 1'b1 || n != NB + 1 || (last_done >= 0 && cyc - last_done != NB + 2)) begin
                n_fail++; bad_time++;
                if (bad_time <= 5)
                    $display("FAIL b2b_timing[%0d]: got done at %0d spacing %0d required %0d spacing %0d",
                             i, n, cyc - last_done, NB + 1, NB + 2);
            end
            last_done = cyc;
            n_tests++;
            if ({result, carry_out, overflow, zero} !== {er, eco, eov, ezo}) begin
                n_fail++; bad_data++;
                if (bad_data <= 5)
                    $display("FAIL b2b_result[%0d]: %h %s %h cin%b got %h c%b v%b z%b required %h c%b v%b z%b",
                             i, va[i], vs[i] ? "-" : "+", vb[i], vc[i], result, carry_out, overflow, zero,
                             er, eco, eov, ezo);
            end
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < NB + 6) begin
            @(posedge clk); #1;
            n++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got busy %b required 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_flags();
        test_sub();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
